// File: rtl/uart_pkg.sv
// uart_pkg: types and default constants shared by the UART receive path
// (and later the transmit side).
//   rx_state_t      - receive sequencer states
//   UART_DATA_BITS  - default data bits per character
//   UART_OVERSAMPLE - default sample ticks per bit period (power of two)
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-character handshake between the receiver and the
// character consumer.
//   rx_data   - received character, LSB = first data bit on the line
//   rx_valid  - rx_data / frame_err hold a character not yet accepted
//   rx_ready  - consumer accepts; transfer when rx_valid && rx_ready
//   frame_err - stop bit was sampled low for the character in rx_data
//   overrun   - one-cycle pulse: a character was dropped because the
//               previous one was still unaccepted
// master = receiver side, slave = consumer side.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/bit_sample_counter.sv
// bit_sample_counter: counts oversampling ticks within one bit period.
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   clr   - restart the count at zero (state entry); wins over tick
//   tick  - oversampling strobe; the count advances only on it
//   mid   - tick arriving while the count sits at OVERSAMPLE/2-1 (bit centre)
//   last  - tick arriving while the count sits at OVERSAMPLE-1 (end of bit)
// mid/last are tick-qualified strobes and are meant to be consumed in the
// same cycle by the controlling FSM.
module bit_sample_counter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic mid,
  output logic last
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  logic [CNT_W-1:0] count;

  // Power-of-two period: the natural rollover gives OVERSAMPLE-1 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign mid  = tick && (count == CNT_W'(OVERSAMPLE / 2 - 1));
  assign last = tick && (count == CNT_W'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer. Synchronizes the serial line, walks
// start / data / stop bits using the oversampling counter, assembles each
// character LSB-first and hands it to the consumer over a valid/ready
// handshake, flagging framing errors and overruns.
//   clk         - system clock
//   rst_n       - synchronous active-low reset
//   sample_tick - strobe at OVERSAMPLE x baud (may be high every cycle)
//   rx_in       - asynchronous serial line, idle high
//   busy        - sequencer is not idle
//   rxIf        - character handshake (rx_data, rx_valid, rx_ready,
//                 frame_err, overrun)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  rx_in,
  output logic                  busy,
  uart_rx_ctrl_if.master        rxIf
);

  localparam int unsigned BIDX_W = $clog2(DATA_BITS);
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

  logic                 rxMeta;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            stateNext;
  logic                 clrCnt;
  logic                 midTick;
  logic                 lastTick;
  logic                 shiftEn;
  logic                 charDone;
  logic                 stopErr;
  logic [BIDX_W-1:0]    bidx;
  logic [DATA_BITS-1:0] shreg;

  // Two-flop synchronizer; resets to the idle line level so reset never
  // looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      rxMeta <= rx_in;
      rx_s   <= rxMeta;
    end
  end

  bit_sample_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_sample_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clrCnt),
    .tick  (sample_tick),
    .mid   (midTick),
    .last  (lastTick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and per-cycle strobes. START measures half a bit from the
  // detected edge; from there every full period lands on a bit centre.
  always_comb begin
    stateNext = state;
    shiftEn   = 1'b0;
    charDone  = 1'b0;
    stopErr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_tick && !rx_s) begin
          stateNext = START;
        end
      end
      START: begin
        if (midTick) begin
          stateNext = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (lastTick) begin
          shiftEn = 1'b1;
          if (bidx == LAST_BIT) begin
            stateNext = STOP;
          end
        end
      end
      STOP: begin
        if (lastTick) begin
          charDone  = 1'b1;
          stopErr   = !rx_s;
          stateNext = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rx_s) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    clrCnt = (stateNext != state);
  end

  // Data-bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bidx  <= '0;
      shreg <= '0;
    end else if (state != DATA) begin
      bidx <= '0;
    end else if (shiftEn) begin
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      bidx  <= (bidx == LAST_BIT) ? '0 : bidx + 1'b1;
    end
  end

  // Output holding register and handshake. A completion may overwrite the
  // held character only if that character is being accepted this very cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxIf.rx_data   <= '0;
      rxIf.rx_valid  <= 1'b0;
      rxIf.frame_err <= 1'b0;
      rxIf.overrun   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rxIf.overrun <= 1'b0;
      busy         <= (stateNext != IDLE);
      if (charDone) begin
        if (!rxIf.rx_valid || rxIf.rx_ready) begin
          rxIf.rx_data   <= shreg;
          rxIf.frame_err <= stopErr;
          rxIf.rx_valid  <= 1'b1;
        end else begin
          rxIf.overrun <= 1'b1;
        end
      end else if (rxIf.rx_valid && rxIf.rx_ready) begin
        rxIf.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scenarios plus randomized frames for uart_rx_ctrl.
// The line is driven as a UART transmitter would (each bit held for
// OVERSAMPLE sample ticks) and received characters are collected at every
// accepted handshake, then compared with what was sent.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DB = UART_DATA_BITS;
  localparam int unsigned OS = UART_OVERSAMPLE;
  // Line change -> two synchronizer flops -> edge on which the FSM reacts.
  localparam int SYNC_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_tick = 1'b1;
  logic rx_in = 1'b1;
  logic busy;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) rxBus ();

  uart_rx_ctrl #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .busy        (busy),
    .rxIf        (rxBus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycNo = 0;
  int startCyc = 0;
  int riseCyc = -1;
  int ovCount = 0;
  int validCycles = 0;
  int readyPulseCyc = -1;
  int rstPulseCyc = -1;
  bit tickMode = 1'b0;
  bit readyRandom = 1'b0;
  bit lastTick = 1'b0;
  bit prevValid = 1'b0;
  logic [DB:0] got[$];
  logic [DB:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply scheduled ready/reset, record a handshake that the
  // coming edge performs, then observe outputs 1 time unit after the edge.
  task automatic cyc();
    int fc;
    fc = cycNo - startCyc;
    if (readyPulseCyc >= 0) rxBus.rx_ready = (fc == readyPulseCyc);
    else if (readyRandom) rxBus.rx_ready = 1'($urandom_range(0, 1));
    if (rstPulseCyc >= 0) rst_n = (fc != rstPulseCyc);
    if (rst_n && rxBus.rx_valid && rxBus.rx_ready)
      got.push_back({rxBus.frame_err, rxBus.rx_data});
    @(posedge clk);
    #1;
    cycNo++;
    lastTick = sample_tick;
    sample_tick = tickMode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rxBus.overrun) ovCount++;
    if (rxBus.rx_valid) validCycles++;
    if (rxBus.rx_valid && !prevValid) riseCyc = cycNo;
    prevValid = rxBus.rx_valid;
  endtask

  task automatic sendTicks(input logic b, input int n);
    int cnt;
    rx_in = b;
    cnt = 0;
    while (cnt < n) begin
      cyc();
      if (lastTick) cnt++;
    end
  endtask

  task automatic sendFrame(input logic [DB-1:0] d, input logic stopBit);
    startCyc = cycNo;
    sendTicks(1'b0, OS);
    for (int i = 0; i < DB; i++) sendTicks(d[i], OS);
    sendTicks(stopBit, OS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovBase;
    logic [DB-1:0] d;
    logic sb;
    int gap;

    rxBus.rx_ready = 1'b0;
    // Reset state
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_rx_data", 32'(rxBus.rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rxBus.rx_valid), 32'h0);
    chk("rst_frame_err", 32'(rxBus.frame_err), 32'h0);
    chk("rst_overrun", 32'(rxBus.overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Good frame 0xA5, consumer always ready, tick every cycle
    rxBus.rx_ready = 1'b1;
    validCycles = 0;
    riseCyc = -1;
    sendFrame(8'hA5, 1'b1);
    sendTicks(1'b1, 4);
    chk("a5_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("a5_char", 32'(got[0]), 32'({1'b0, 8'hA5}));
    chk("a5_valid_cycles", 32'(validCycles), 32'd1);
    chk("a5_latency", 32'(riseCyc - startCyc), 32'(SYNC_LAT + OS / 2 + (DB + 1) * OS));
    chk("a5_valid_low", 32'(rxBus.rx_valid), 32'h0);
    got.delete();

    // Start glitch: low for 4 ticks only
    sendTicks(1'b0, 4);
    chk("glitch_busy_start", 32'(busy), 32'h1);
    sendTicks(1'b1, 20);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_valid", 32'(rxBus.rx_valid), 32'h0);
    chk("glitch_no_char", 32'(got.size()), 32'd0);

    // Overrun: two characters, nobody accepting
    rxBus.rx_ready = 1'b0;
    ovBase = ovCount;
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    sendTicks(1'b1, 4);
    chk("ovr_pulses", 32'(ovCount - ovBase), 32'd1);
    chk("ovr_data_kept", 32'(rxBus.rx_data), 32'h11);
    chk("ovr_valid", 32'(rxBus.rx_valid), 32'h1);
    rxBus.rx_ready = 1'b1;
    cyc();
    rxBus.rx_ready = 1'b0;
    cyc();
    chk("ovr_valid_fall", 32'(rxBus.rx_valid), 32'h0);
    chk("ovr_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("ovr_char", 32'(got[0]), 32'({1'b0, 8'h11}));
    got.delete();

    // Completion coincident with acceptance of the held character
    ovBase = ovCount;
    sendFrame(8'h55, 1'b1);
    readyPulseCyc = SYNC_LAT + OS / 2 + (DB + 1) * OS - 1;
    sendFrame(8'h66, 1'b1);
    readyPulseCyc = -1;
    rxBus.rx_ready = 1'b0;
    sendTicks(1'b1, 2);
    chk("coin_data", 32'(rxBus.rx_data), 32'h66);
    chk("coin_valid", 32'(rxBus.rx_valid), 32'h1);
    chk("coin_no_overrun", 32'(ovCount - ovBase), 32'd0);
    chk("coin_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("coin_char", 32'(got[0]), 32'({1'b0, 8'h55}));
    rxBus.rx_ready = 1'b1;
    cyc();
    rxBus.rx_ready = 1'b0;
    got.delete();

    // Framing error followed by a long break; character left pending
    ovBase = ovCount;
    sendFrame(8'h3C, 1'b0);
    sendTicks(1'b0, 40);
    chk("fe_busy_break", 32'(busy), 32'h1);
    chk("fe_data", 32'(rxBus.rx_data), 32'h3C);
    chk("fe_flag", 32'(rxBus.frame_err), 32'h1);
    chk("fe_valid", 32'(rxBus.rx_valid), 32'h1);
    sendTicks(1'b1, 20);
    chk("fe_busy_idle", 32'(busy), 32'h0);
    chk("fe_no_second", 32'(ovCount - ovBase), 32'd0);
    chk("fe_data_held", 32'(rxBus.rx_data), 32'h3C);

    // Reset pulse in the middle of data bit 4 with a character still pending
    ovBase = ovCount;
    rstPulseCyc = OS + 4 * OS + OS / 2;
    sendFrame(8'hF0, 1'b1);
    rstPulseCyc = -1;
    rst_n = 1'b1;
    sendTicks(1'b1, 4);
    chk("mrst_rx_data", 32'(rxBus.rx_data), 32'h0);
    chk("mrst_rx_valid", 32'(rxBus.rx_valid), 32'h0);
    chk("mrst_frame_err", 32'(rxBus.frame_err), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_no_overrun", 32'(ovCount - ovBase), 32'd0);
    chk("mrst_no_char", 32'(got.size()), 32'd0);

    rxBus.rx_ready = 1'b1;
    sendFrame(8'h81, 1'b1);
    sendTicks(1'b1, 4);
    chk("post_rst_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("post_rst_char", 32'(got[0]), 32'({1'b0, 8'h81}));
    got.delete();

    // Randomized frames, sparse ticks, random consumer readiness
    ovBase = ovCount;
    tickMode = 1'b1;
    readyRandom = 1'b1;
    for (int f = 0; f < 24; f++) begin
      d = DB'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      expq.push_back({~sb, d});
      sendFrame(d, sb);
      gap = sb ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
      sendTicks(1'b1, gap);
      readyRandom = 1'b0;
      rxBus.rx_ready = 1'b1;
      repeat (3) cyc();
      readyRandom = 1'b1;
    end
    readyRandom = 1'b0;
    rxBus.rx_ready = 1'b0;
    chk("rand_count", 32'(got.size()), 32'(expq.size()));
    chk("rand_no_overrun", 32'(ovCount - ovBase), 32'd0);
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("rand_char_%0d", i), 32'(got[i]), 32'(expq[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
